// File: rtl/seg7_capture.sv
// seg7_capture: decodes a multiplexed active-low 7-segment bus into per-position digit codes
module seg7_capture #(
   parameter int DIGITS        = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  iCLK,
   input  logic                  iRST_N,
   input  logic [6:0]            iSEG,
   input  logic [DIGITS-1:0]     iSEL,
   output logic [4:0]            oDIG,
   output logic [2:0]            oPOS,
   output logic                  oVALID,
   output logic                  oERR,
   output logic [5*DIGITS-1:0]   oDIGITS
);

   typedef enum logic [1:0] {IDLE, SETTLE, COMMIT, HOLD} state_t;

   localparam logic [7:0] STABLE    = 8'(STABLE_CYCLES);
   // A single required sample means a fresh sample is already stable enough to commit.
   localparam state_t     LOADSTATE = (STABLE_CYCLES == 1) ? COMMIT : SETTLE;

   state_t              state;
   logic                rstMeta, rstSync;
   logic [6:0]          sSeg, refSeg;
   logic [DIGITS-1:0]   sSel, refSel;
   logic [7:0]          cnt;
   logic [4:0]          code;
   logic                codeErr, selOk, sameSample, sameRef;

   function automatic logic [2:0] encPos(input logic [DIGITS-1:0] sel);
      encPos = '0;
      for (int i = 0; i < DIGITS; i++)
         if (sel[i]) encPos = 3'(i);
   endfunction

   assign selOk      = (iSEL != '0) && ((iSEL & (iSEL - DIGITS'(1))) == '0);
   assign sameSample = (iSEG == sSeg) && (iSEL == sSel);
   // After a commit, changes are judged against the committed sample so that a
   // change landing on the commit edge itself is not lost.
   assign sameRef    = (iSEG == refSeg) && (iSEL == refSel);

   // Two-flop reset synchroniser: asserts immediately, releases on the second edge.
   always_ff @(posedge iCLK or negedge iRST_N)
      if (!iRST_N) {rstSync, rstMeta} <= 2'b00;
      else         {rstSync, rstMeta} <= {rstMeta, 1'b1};

   // Segment pattern to digit code; unknown patterns flag an error.
   always_comb begin
      code    = 5'h10;
      codeErr = 1'b0;
      case (sSeg)
         7'b1000000: code = 5'h00;
         7'b1111001: code = 5'h01;
         7'b0100100: code = 5'h02;
         7'b0110000: code = 5'h03;
         7'b0011001: code = 5'h04;
         7'b0010010: code = 5'h05;
         7'b0000010: code = 5'h06;
         7'b1111000: code = 5'h07;
         7'b0000000: code = 5'h08;
         7'b0011000: code = 5'h09;
         7'b0001000: code = 5'h0A;
         7'b0000011: code = 5'h0B;
         7'b1000110: code = 5'h0C;
         7'b0100001: code = 5'h0D;
         7'b0000110: code = 5'h0E;
         7'b0001110: code = 5'h0F;
         7'b1111111: code = 5'h1F;
         default:    codeErr = 1'b1;
      endcase
   end

   // Sampling, stability counting and commit of the held digit into the register file.
   always_ff @(posedge iCLK or negedge rstSync)
      if (!rstSync) begin
         state   <= IDLE;
         cnt     <= '0;
         sSeg    <= 7'h7F;
         sSel    <= '0;
         refSeg  <= 7'h7F;
         refSel  <= '0;
         oVALID  <= 1'b0;
         oERR    <= 1'b0;
         oDIG    <= 5'h1F;
         oPOS    <= '0;
         oDIGITS <= {DIGITS{5'h1F}};
      end else begin
         sSeg   <= iSEG;
         sSel   <= iSEL;
         oVALID <= 1'b0;
         case (state)
            IDLE:
               if (selOk) begin
                  state <= LOADSTATE;
                  cnt   <= 8'd1;
               end else cnt <= '0;
            SETTLE:
               if (!selOk) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (sameSample) begin
                  cnt   <= cnt + 8'd1;
                  state <= (cnt + 8'd1 == STABLE) ? COMMIT : SETTLE;
               end else begin
                  state <= LOADSTATE;
                  cnt   <= 8'd1;
               end
            COMMIT: begin
               state  <= HOLD;
               oVALID <= 1'b1;
               oDIG   <= code;
               oERR   <= codeErr;
               oPOS   <= encPos(sSel);
               refSeg <= sSeg;
               refSel <= sSel;
               for (int p = 0; p < DIGITS; p++)
                  if (sSel[p]) oDIGITS[5*p +: 5] <= code;
            end
            HOLD:
               if (!selOk) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (!sameRef) begin
                  state <= LOADSTATE;
                  cnt   <= 8'd1;
               end
            default: state <= IDLE;
         endcase
      end

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed-vector bench for seg7_capture with default parameters
module tb_seg7_capture;

   logic        iCLK = 1'b0;
   logic        iRST_N = 1'b0;
   logic [6:0]  iSEG = 7'h7F;
   logic [7:0]  iSEL = '0;
   logic [4:0]  oDIG;
   logic [2:0]  oPOS;
   logic        oVALID, oERR;
   logic [39:0] oDIGITS;

   int          nCmp = 0;
   int          nBad = 0;
   int          lat;
   logic [8:0]  pulseQ[$];
   logic [39:0] expDigits;
   logic [6:0]  pat[16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   seg7_capture #(.DIGITS(8), .STABLE_CYCLES(4)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iSEG(iSEG), .iSEL(iSEL),
      .oDIG(oDIG), .oPOS(oPOS), .oVALID(oVALID), .oERR(oERR), .oDIGITS(oDIGITS)
   );

   always #5 iCLK = ~iCLK;

   // Record every commit pulse as {dig, pos, err}, sampled mid-cycle.
   always @(negedge iCLK)
      if (oVALID) pulseQ.push_back({oDIG, oPOS, oERR});

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCmp++;
      if (obs !== exp) begin
         nBad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge iCLK);
   endtask

   initial begin
      // reset with random inputs
      repeat (4) begin
         iSEG = 7'($urandom);
         iSEL = 8'($urandom);
         step(1);
      end
      checkVal("rst_valid", oVALID, 1'b0);
      checkVal("rst_err", oERR, 1'b0);
      checkVal("rst_dig", oDIG, 5'h1F);
      checkVal("rst_pos", oPOS, 3'd0);
      checkVal("rst_digits", oDIGITS, {8{5'h1F}});
      iSEL = '0;
      iRST_N = 1'b1;
      step(4);

      // full decode sweep on position 2
      pulseQ.delete();
      iSEL = 8'b00000100;
      for (int h = 0; h < 16; h++) begin
         iSEG = pat[h];
         step(6);
      end
      checkVal("sweep_count", pulseQ.size(), 16);
      for (int i = 0; i < pulseQ.size() && i < 16; i++)
         checkVal($sformatf("sweep_%0d", i), pulseQ[i], {5'(i), 3'd2, 1'b0});
      checkVal("sweep_field", oDIGITS[14:10], 5'hF);

      // glitch rejection: 2 for 3 cycles then 3
      pulseQ.delete();
      iSEG = pat[2];
      step(3);
      iSEG = pat[3];
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge iCLK);
         if (oVALID && lat == 0) lat = k;
      end
      checkVal("glitch_count", pulseQ.size(), 1);
      if (pulseQ.size() > 0) checkVal("glitch_pulse", pulseQ[0], {5'h3, 3'd2, 1'b0});
      checkVal("glitch_latency", lat, 5);

      // scan loopback through all positions
      pulseQ.delete();
      expDigits = '0;
      for (int p = 0; p < 8; p++) begin
         iSEL = 8'(1 << p);
         iSEG = pat[p+1];
         expDigits[5*p +: 5] = 5'(p + 1);
         step(10);
      end
      checkVal("scan_count", pulseQ.size(), 8);
      for (int i = 0; i < pulseQ.size() && i < 8; i++)
         checkVal($sformatf("scan_%0d", i), pulseQ[i], {5'(i + 1), 3'(i), 1'b0});
      checkVal("scan_digits", oDIGITS, expDigits);

      // unrecognised pattern
      pulseQ.delete();
      iSEL = 8'b00000001;
      iSEG = 7'b0101010;
      step(8);
      checkVal("err_count", pulseQ.size(), 1);
      if (pulseQ.size() > 0) checkVal("err_pulse", pulseQ[0], {5'h10, 3'd0, 1'b1});
      checkVal("err_field", oDIGITS[4:0], 5'h10);

      // blank
      pulseQ.delete();
      iSEG = 7'b1111111;
      step(8);
      checkVal("blank_count", pulseQ.size(), 1);
      if (pulseQ.size() > 0) checkVal("blank_pulse", pulseQ[0], {5'h1F, 3'd0, 1'b0});
      checkVal("blank_field", oDIGITS[4:0], 5'h1F);

      // multi-hot select never commits
      pulseQ.delete();
      iSEL = 8'b00000011;
      iSEG = pat[5];
      step(10);
      checkVal("multihot_count", pulseQ.size(), 0);
      checkVal("multihot_dig", oDIG, 5'h1F);

      // reset two cycles into a stable digit, then release
      pulseQ.delete();
      iSEL = 8'b00001000;
      iSEG = pat[9];
      step(2);
      iRST_N = 1'b0;
      #1;
      checkVal("midrst_digits", oDIGITS, {8{5'h1F}});
      checkVal("midrst_valid", oVALID, 1'b0);
      step(3);
      checkVal("midrst_count", pulseQ.size(), 0);
      iRST_N = 1'b1;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge iCLK);
         if (oVALID && lat == 0) lat = k;
      end
      checkVal("release_latency", lat, 7);
      checkVal("release_dig", oDIG, 5'h9);
      checkVal("release_pos", oPOS, 3'd3);
      checkVal("release_field", oDIGITS[19:15], 5'h9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
